// File: rtl/lfsr_desrandomizador_pkg.sv
// rtl/lfsr_desrandomizador_pkg.sv - shared LFSR constants, FSM state type and step helpers
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;

  // Forward taps on bits 0, 2, 3, 5 (x^16 + x^14 + x^13 + x^11), shift right.
  localparam logic [LFSR_WIDTH-1:0] TAPS_AVANCO = 16'b0000_0000_0010_1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  function automatic logic [LFSR_WIDTH-1:0] passo_avanco(input logic [LFSR_WIDTH-1:0] o);
    return {^(o & TAPS_AVANCO), o[LFSR_WIDTH-1:1]};
  endfunction

  // Old bit t sits at new bit t-1, so the lost bit 0 is recovered from the feedback bit.
  function automatic logic [LFSR_WIDTH-1:0] passo_reverso(input logic [LFSR_WIDTH-1:0] n);
    return {n[LFSR_WIDTH-2:0], n[LFSR_WIDTH-1] ^ (^(n & (TAPS_AVANCO >> 1)))};
  endfunction

endpackage

// File: rtl/lfsr_desrandomizador_if.sv
// rtl/lfsr_desrandomizador_if.sv - start/busy/done request interface of the LFSR descrambler
interface lfsr_desrandomizador_if
  import lfsr_pkg::*;
#(
  parameter int STEP_W = 8
);

  logic                  start;
  logic [LFSR_WIDTH-1:0] entrada;
  logic [STEP_W-1:0]     passos;
  logic [LFSR_WIDTH-1:0] saida;
  logic                  ocupado;
  logic                  pronto;
  logic                  erro_zero;

  modport master (
    output start, entrada, passos,
    input  saida, ocupado, pronto, erro_zero
  );

  modport slave (
    input  start, entrada, passos,
    output saida, ocupado, pronto, erro_zero
  );

endinterface

// File: rtl/lfsr_passo_reverso.sv
// rtl/lfsr_passo_reverso.sv - one combinational reverse step of the 16-bit Fibonacci LFSR
module lfsr_passo_reverso
  import lfsr_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] novo_i,
  output logic [LFSR_WIDTH-1:0] antigo_o
);

  assign antigo_o = passo_reverso(novo_i);

endmodule

// File: rtl/lfsr_desrandomizador.sv
// rtl/lfsr_desrandomizador.sv - walks the scrambler LFSR backwards by a programmable step count
module lfsr_desrandomizador
  import lfsr_pkg::*;
#(
  parameter int STEP_W = 8
)(
  input  logic                 clock,
  input  logic                 reset,
  lfsr_desrandomizador_if.slave bus
);

  estado_t               estado_q;
  logic [LFSR_WIDTH-1:0] reg_q;
  logic [LFSR_WIDTH-1:0] reg_d;
  logic [STEP_W-1:0]     cnt_q;
  logic                  ocupado_q;
  logic                  pronto_q;
  logic                  erro_q;

  lfsr_passo_reverso u_passo (
    .novo_i   (reg_q),
    .antigo_o (reg_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= IDLE;
      reg_q     <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      case (estado_q)
        IDLE: begin
          pronto_q <= 1'b0;
          if (bus.start) begin
            reg_q     <= bus.entrada;
            cnt_q     <= bus.passos;
            erro_q    <= (bus.entrada == '0);
            ocupado_q <= 1'b1;
            if (bus.passos == '0) begin
              estado_q <= DONE;
              pronto_q <= 1'b1;
            end else begin
              estado_q <= RUN;
            end
          end
        end
        // Leaving at cnt=1 keeps the decrement from ever wrapping.
        RUN: begin
          reg_q <= reg_d;
          cnt_q <= cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) begin
            estado_q <= DONE;
            pronto_q <= 1'b1;
          end
        end
        DONE: begin
          estado_q  <= IDLE;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q  <= IDLE;
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.saida     = reg_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.pronto    = pronto_q;
  assign bus.erro_zero = erro_q;

endmodule

// File: tb/tb_lfsr_desrandomizador.sv
// tb/tb_lfsr_desrandomizador.sv - self-checking bench for lfsr_desrandomizador
module tb_lfsr_desrandomizador;

  logic clock;
  logic reset;

  lfsr_desrandomizador_if #(.STEP_W(8)) bus ();

  lfsr_desrandomizador #(.STEP_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] entrada;
    logic [7:0]  passos;
    logic [15:0] saida_exp;
    logic        erro_exp;
  } vetor_t;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  // Forward scrambler step written directly from the polynomial.
  function automatic logic [15:0] avanco(input logic [15:0] o);
    logic fb;
    fb = o[0] ^ o[2] ^ o[3] ^ o[5];
    return {fb, o[15:1]};
  endfunction

  // Issues one request and follows it to completion; latencia is the cycle after E0 in
  // which pronto is seen (1 = cycle right after E0), ocup counts cycles with ocupado high.
  task automatic pedido(input logic [15:0] e, input logic [7:0] p,
                        output logic [15:0] s, output logic erro,
                        output int latencia, output int ocup);
    int n;
    @(negedge clock);
    bus.start   = 1'b1;
    bus.entrada = e;
    bus.passos  = p;
    @(negedge clock);
    bus.start = 1'b0;
    n = 1;
    ocup = 0;
    latencia = -1;
    while (n < 400 && latencia < 0) begin
      if (bus.ocupado) ocup++;
      if (bus.pronto) begin
        latencia = n;
        s = bus.saida;
        erro = bus.erro_zero;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    if (latencia < 0) begin
      check("timeout_pronto", 32'd0, 32'd1);
      s = 'x;
      erro = 1'bx;
    end else begin
      @(negedge clock);
      check("pronto_one_cycle", {31'd0, bus.pronto}, 32'd0);
      check("ocupado_falls", {31'd0, bus.ocupado}, 32'd0);
      check("saida_held", {16'd0, bus.saida}, {16'd0, s});
    end
  endtask

  initial begin
    vetor_t tabela[6];
    logic [15:0] s;
    logic erro;
    int lat, ocup;

    tabela[0] = '{16'h8000, 8'd1, 16'h0001, 1'b0};
    tabela[1] = '{16'h8000, 8'd2, 16'h0002, 1'b0};
    tabela[2] = '{16'hFFFF, 8'd1, 16'hFFFE, 1'b0};
    tabela[3] = '{16'h1234, 8'd0, 16'h1234, 1'b0};
    tabela[4] = '{16'h0000, 8'd5, 16'h0000, 1'b1};
    tabela[5] = '{16'h0001, 8'd0, 16'h0001, 1'b0};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.entrada = '0;
    bus.passos = '0;
    repeat (3) @(negedge clock);
    check("reset_saida", {16'd0, bus.saida}, 32'd0);
    check("reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
    check("reset_pronto", {31'd0, bus.pronto}, 32'd0);
    check("reset_erro", {31'd0, bus.erro_zero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pedido(tabela[i].entrada, tabela[i].passos, s, erro, lat, ocup);
      check($sformatf("vec%0d_saida", i), {16'd0, s}, {16'd0, tabela[i].saida_exp});
      check($sformatf("vec%0d_erro", i), {31'd0, erro}, {31'd0, tabela[i].erro_exp});
      check($sformatf("vec%0d_latencia", i), lat, tabela[i].passos + 1);
      check($sformatf("vec%0d_ocupado", i), ocup, tabela[i].passos + 1);
    end

    // Round trip against the forward scrambler.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] semente, w;
      int k;
      semente = 16'($urandom_range(1, 16'hFFFF));
      k = $urandom_range(1, 255);
      w = semente;
      for (int j = 0; j < k; j++) w = avanco(w);
      pedido(w, 8'(k), s, erro, lat, ocup);
      check("roundtrip_saida", {16'd0, s}, {16'd0, semente});
      check("roundtrip_latencia", lat, k + 1);
    end

    // start held high with passos=0: pronto on every other cycle.
    @(negedge clock);
    bus.start = 1'b1;
    bus.entrada = 16'hABCD;
    bus.passos = 8'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("b2b_pronto", {31'd0, bus.pronto}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clock);

    // passos=10, start during RUN must be ignored, then reset at E3.
    bus.start = 1'b1;
    bus.entrada = 16'h5A5A;
    bus.passos = 8'd10;
    @(negedge clock);
    bus.entrada = 16'h1111;
    bus.passos = 8'd0;
    @(negedge clock);
    bus.start = 1'b0;
    check("run_ignore_pronto", {31'd0, bus.pronto}, 32'd0);
    check("run_ignore_ocupado", {31'd0, bus.ocupado}, 32'd1);
    @(negedge clock);
    check("run_ignore_pronto2", {31'd0, bus.pronto}, 32'd0);
    reset = 1'b1;
    #1;
    check("midrun_reset_saida", {16'd0, bus.saida}, 32'd0);
    check("midrun_reset_ocupado", {31'd0, bus.ocupado}, 32'd0);
    check("midrun_reset_pronto", {31'd0, bus.pronto}, 32'd0);
    check("midrun_reset_erro", {31'd0, bus.erro_zero}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("post_reset_no_pronto", {31'd0, bus.pronto}, 32'd0);
    end
    pedido(16'h8000, 8'd2, s, erro, lat, ocup);
    check("after_reset_saida", {16'd0, s}, 32'h0002);
    check("after_reset_latencia", lat, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
